// File: rtl/wb_cmd_master_if.sv
// Command/response stream and Wishbone pipelined bus bundle for wb_cmd_master.
// Signal names match the original flat port list so callers map one-to-one.
interface wb_cmd_master_if #(
    parameter int G_ADDR_SIZE = 8,
    parameter int G_DATA_SIZE = 16
) ();
    logic                   s_valid_i;
    logic                   s_ready_o;
    logic                   s_we_i;
    logic [G_ADDR_SIZE-1:0] s_addr_i;
    logic [G_DATA_SIZE-1:0] s_data_i;

    logic                   m_valid_o;
    logic                   m_ready_i;
    logic [G_DATA_SIZE-1:0] m_data_o;
    logic                   m_err_o;

    logic                   wb_cyc_o;
    logic                   wb_stb_o;
    logic                   wb_stall_i;
    logic                   wb_ack_i;
    logic                   wb_we_o;
    logic [G_ADDR_SIZE-1:0] wb_addr_o;
    logic [G_DATA_SIZE-1:0] wb_data_o;
    logic [G_DATA_SIZE-1:0] wb_data_i;

    modport master (
        input  s_valid_i, s_we_i, s_addr_i, s_data_i,
        output s_ready_o,
        output m_valid_o, m_data_o, m_err_o,
        input  m_ready_i,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o,
        input  wb_stall_i, wb_ack_i, wb_data_i
    );

    modport slave (
        output s_valid_i, s_we_i, s_addr_i, s_data_i,
        input  s_ready_o,
        input  m_valid_o, m_data_o, m_err_o,
        output m_ready_i,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o,
        output wb_stall_i, wb_ack_i, wb_data_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone pipelined master: one bus transaction and one
// response per command, with a cycle timeout that aborts unanswered requests.
module wb_cmd_master #(
    parameter int G_ADDR_SIZE = 8,
    parameter int G_DATA_SIZE = 16,
    parameter int G_TIMEOUT   = 15
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    wb_cmd_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    localparam int CNT_W = $clog2(G_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(G_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   stb_q, stb_d;
    logic                   we_q, we_d;
    logic [G_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [G_DATA_SIZE-1:0] wdata_q, wdata_d;
    logic                   mvalid_q, mvalid_d;
    logic [G_DATA_SIZE-1:0] mdata_q, mdata_d;
    logic                   merr_q, merr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   s_ready;

    assign s_ready = (state_q == IDLE) && rst_n_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            merr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            merr_q   <= merr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        stb_d    = stb_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        merr_d   = merr_q;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (bus.s_valid_i && s_ready) begin
                    we_d    = bus.s_we_i;
                    addr_d  = bus.s_addr_i;
                    wdata_d = bus.s_we_i ? bus.s_data_i : '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cnt_q == CNT_LAST) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    mvalid_d = 1'b1;
                    merr_d   = 1'b1;
                    mdata_d  = '0;
                    state_d  = RESP;
                end else if (!bus.wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // ACK on the timeout edge still counts as a normal completion.
                if (bus.wb_ack_i) begin
                    mdata_d  = we_q ? '0 : bus.wb_data_i;
                    merr_d   = 1'b0;
                    mvalid_d = 1'b1;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    mvalid_d = 1'b1;
                    merr_d   = 1'b1;
                    mdata_d  = '0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q;
                if (bus.m_ready_i) begin
                    mvalid_d = 1'b0;
                    mdata_d  = '0;
                    merr_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_valid_o = mvalid_q;
    assign bus.m_data_o  = mdata_q;
    assign bus.m_err_o   = merr_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_addr_o = addr_q;
    assign bus.wb_data_o = wdata_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised bench for wb_cmd_master against a memory-backed Wishbone slave
// and a command-level reference model of expected responses and latencies.
module tb_wb_cmd_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16)) bus ();

    wb_cmd_master #(.G_ADDR_SIZE(8), .G_DATA_SIZE(16), .G_TIMEOUT(15)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    // Slave model state
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    int          stall_cfg = 0;
    int          stall_left = 0;
    logic        ack_en = 1'b1;
    logic        ack_force = 1'b0;
    logic        ack_q = 1'b0;
    logic [15:0] rdata_q = 16'hDEAD;
    int          req_cnt = 0;
    int          viol_cnt = 0;

    function automatic logic [15:0] init_word(int i);
        return 16'(i * 32'h1357) ^ 16'hA5A5;
    endfunction

    initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

    assign bus.wb_stall_i = bus.wb_stb_o && (stall_left != 0);
    assign bus.wb_ack_i   = ack_q | ack_force;
    assign bus.wb_data_i  = rdata_q;

    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (!bus.wb_cyc_o) stall_left <= stall_cfg;
        else if (bus.wb_stb_o && stall_left != 0) stall_left <= stall_left - 1;
        ack_q   <= 1'b0;
        rdata_q <= 16'hDEAD;
        if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_stall_i) begin
            req_cnt <= req_cnt + 1;
            if (ack_en) begin
                ack_q <= 1'b1;
                if (bus.wb_we_o) begin
                    mem[bus.wb_addr_o] <= bus.wb_data_o;
                    rdata_q <= 16'h5A5A;
                end else begin
                    rdata_q <= mem[bus.wb_addr_o];
                end
            end
        end
        if (bus.wb_stb_o && !bus.wb_cyc_o) viol_cnt <= viol_cnt + 1;
    end

    task automatic send_cmd(input logic we, input logic [7:0] a, input logic [15:0] d,
                            output int t_acc, output bit ok);
        ok = 1'b0;
        bus.s_valid_i = 1'b1;
        bus.s_we_i    = we;
        bus.s_addr_i  = a;
        bus.s_data_i  = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.s_ready_o) ok = 1'b1;
            @(posedge clk); #1;
        end
        t_acc = cycle_cnt;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 16'(16'h0F0F ^ 16'($urandom));
    endtask

    task automatic wait_resp(input int t_acc, output int lat, output logic [15:0] d,
                             output logic e, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.m_valid_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        lat = cycle_cnt - t_acc;
        d   = bus.m_data_o;
        e   = bus.m_err_o;
    endtask

    task automatic handshake();
        bus.m_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.m_ready_i = 1'b0;
    endtask

    // Expected response for a command, from the command-level memory model.
    function automatic logic [15:0] model_cmd(logic we, logic [7:0] a, logic [15:0] d);
        logic [15:0] r;
        if (we) begin
            ref_mem[a] = d;
            r = '0;
        end else begin
            r = ref_mem[a];
        end
        return r;
    endfunction

    task automatic test_reset();
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.m_valid_o, bus.m_err_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.m_valid_o, bus.m_err_o});
        end
        checks++;
        if ({bus.wb_addr_o, bus.wb_data_o, bus.m_data_o} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", {bus.wb_addr_o, bus.wb_data_o, bus.m_data_o});
        end
        checks++;
        if (bus.s_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=0", bus.s_ready_o);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.s_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.s_ready_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        int t, lat;
        logic [15:0] d, exp;
        logic e;
        bit ok;
        exp = model_cmd(1'b1, 8'h12, 16'hBEEF);
        send_cmd(1'b1, 8'h12, 16'hBEEF, t, ok);
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_addr_o, bus.wb_data_o} !== {3'b111, 8'h12, 16'hBEEF}) begin
            errors++;
            $display("FAIL wr_bus got=%b%b%b %h %h exp=111 12 beef", bus.wb_cyc_o, bus.wb_stb_o,
                     bus.wb_we_o, bus.wb_addr_o, bus.wb_data_o);
        end
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || lat !== 2 || d !== exp || e !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got ok=%0d lat=%0d data=%h err=%b exp lat=2 data=%h err=0",
                     ok, lat, d, e, exp);
        end
        handshake();
        exp = model_cmd(1'b0, 8'h12, 16'h0);
        send_cmd(1'b0, 8'h12, 16'h1111, t, ok);
        checks++;
        if (bus.wb_data_o !== 16'h0 || bus.wb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_bus_wdata got=%h we=%b exp=0 we=0", bus.wb_data_o, bus.wb_we_o);
        end
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || lat !== 2 || d !== 16'hBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp got ok=%0d lat=%0d data=%h err=%b exp lat=2 data=beef err=0",
                     ok, lat, d, e);
        end
        handshake();
    endtask

    task automatic test_stall();
        int t, lat, r0;
        logic [15:0] d, exp;
        logic e;
        bit ok, held;
        stall_cfg = 3;
        @(posedge clk); #1;
        r0 = req_cnt;
        exp = model_cmd(1'b0, 8'h05, 16'h0);
        send_cmd(1'b0, 8'h05, 16'h0, t, ok);
        held = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.wb_stb_o !== 1'b1 || bus.wb_addr_o !== 8'h05 || bus.wb_we_o !== 1'b0) held = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL stall_hold got=0 exp=1");
        end
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || lat !== 5 || d !== exp || e !== 1'b0 || req_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL stall_resp got ok=%0d lat=%0d data=%h err=%b reqs=%0d exp lat=5 data=%h err=0 reqs=1",
                     ok, lat, d, e, req_cnt - r0, exp);
        end
        handshake();
        stall_cfg = 0;
    endtask

    task automatic test_timeout();
        int t, lat;
        logic [15:0] d, exp;
        logic e;
        bit ok;
        ack_en = 1'b0;
        send_cmd(1'b0, 8'h33, 16'h0, t, ok);
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || lat !== 15 || d !== 16'h0 || e !== 1'b1 || bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_resp got ok=%0d lat=%0d data=%h err=%b cyc=%b exp lat=15 data=0 err=1 cyc=0",
                     ok, lat, d, e, bus.wb_cyc_o);
        end
        handshake();
        ack_en = 1'b1;
        exp = model_cmd(1'b0, 8'h33, 16'h0);
        send_cmd(1'b0, 8'h33, 16'h0, t, ok);
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || lat !== 2 || d !== exp || e !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover got ok=%0d lat=%0d data=%h err=%b exp lat=2 data=%h err=0",
                     ok, lat, d, e, exp);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int t, lat;
        logic [15:0] d, exp;
        logic e;
        bit ok, stable;
        exp = model_cmd(1'b0, 8'h40, 16'h0);
        send_cmd(1'b0, 8'h40, 16'h0, t, ok);
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || d !== exp || e !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp got ok=%0d data=%h err=%b exp data=%h err=0", ok, d, e, exp);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.m_valid_o !== 1'b1 || bus.m_data_o !== d || bus.m_err_o !== e || bus.s_ready_o !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_stable got=0 exp=1");
        end
        handshake();
        checks++;
        if (bus.s_ready_o !== 1'b1 || bus.m_valid_o !== 1'b0 || bus.m_data_o !== 16'h0) begin
            errors++;
            $display("FAIL bp_after got ready=%b valid=%b data=%h exp ready=1 valid=0 data=0",
                     bus.s_ready_o, bus.m_valid_o, bus.m_data_o);
        end
    endtask

    task automatic test_reset_mid();
        int t, lat;
        logic [15:0] d, exp;
        logic e;
        bit ok;
        send_cmd(1'b0, 8'h21, 16'h0, t, ok);
        @(posedge clk); #1;
        checks++;
        if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_wait got cyc=%b stb=%b exp cyc=1 stb=0", bus.wb_cyc_o, bus.wb_stb_o);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.m_valid_o, bus.s_ready_o} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_drop got=%b exp=0000",
                     {bus.wb_cyc_o, bus.wb_stb_o, bus.m_valid_o, bus.s_ready_o});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_discard got valid=%b exp=0", bus.m_valid_o);
        end
        exp = model_cmd(1'b0, 8'h00, 16'h0);
        send_cmd(1'b0, 8'h00, 16'h0, t, ok);
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || lat !== 2 || d !== exp || e !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after got ok=%0d lat=%0d data=%h err=%b exp lat=2 data=%h err=0",
                     ok, lat, d, e, exp);
        end
        handshake();
    endtask

    task automatic test_spurious_ack();
        int t, lat, r0;
        logic [15:0] d, exp;
        logic e;
        bit ok, quiet;
        ack_force = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.m_valid_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL spur_idle got valid=1 exp=0");
        end
        stall_cfg = 2;
        r0 = req_cnt;
        exp = model_cmd(1'b0, 8'h07, 16'h0);
        send_cmd(1'b0, 8'h07, 16'h0, t, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ack_force = 1'b0;
        checks++;
        if (bus.m_valid_o !== 1'b0 || bus.wb_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL spur_req got valid=%b stb=%b exp valid=0 stb=1", bus.m_valid_o, bus.wb_stb_o);
        end
        wait_resp(t, lat, d, e, ok);
        checks++;
        if (!ok || lat !== 4 || d !== exp || e !== 1'b0) begin
            errors++;
            $display("FAIL spur_resp got ok=%0d lat=%0d data=%h err=%b exp lat=4 data=%h err=0",
                     ok, lat, d, e, exp);
        end
        handshake();
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.m_valid_o !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || req_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL spur_single got quiet=%0d reqs=%0d exp quiet=1 reqs=1", quiet, req_cnt - r0);
        end
        stall_cfg = 0;
    endtask

    task automatic test_random();
        int t, lat, r0, st, bp;
        logic [15:0] d, exp, wd;
        logic [7:0] a;
        logic we, e;
        bit ok;
        for (int n = 0; n < 24; n++) begin
            we = 1'($urandom);
            a  = 8'($urandom_range(0, 7));
            wd = 16'($urandom);
            st = int'($urandom_range(0, 3));
            bp = int'($urandom_range(0, 3));
            stall_cfg = st;
            @(posedge clk); #1;
            r0 = req_cnt;
            exp = model_cmd(we, a, wd);
            send_cmd(we, a, wd, t, ok);
            wait_resp(t, lat, d, e, ok);
            checks++;
            if (!ok || lat !== 2 + st || d !== exp || e !== 1'b0) begin
                errors++;
                $display("FAIL rand_resp[%0d] got ok=%0d lat=%0d data=%h err=%b exp lat=%0d data=%h err=0",
                         n, ok, lat, d, e, 2 + st, exp);
            end
            repeat (bp) begin
                @(posedge clk); #1;
            end
            handshake();
            checks++;
            if (req_cnt - r0 !== 1 || bus.m_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_single[%0d] got reqs=%0d valid=%b exp reqs=1 valid=0",
                         n, req_cnt - r0, bus.m_valid_o);
            end
        end
        stall_cfg = 0;
    endtask

    task automatic test_protocol();
        checks++;
        if (viol_cnt !== 0) begin
            errors++;
            $display("FAIL stb_without_cyc got=%0d exp=0", viol_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        bus.s_valid_i = 1'b0;
        bus.s_we_i    = 1'b0;
        bus.s_addr_i  = '0;
        bus.s_data_i  = '0;
        bus.m_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_stall();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_spurious_ack();
        test_random();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end
endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone pipelined master that sits directly upstream of the on-chip wb_mem slave.
- Converts a valid/ready command stream (read or write, address, data) into single Wishbone transactions.
- Returns exactly one response per command on a valid/ready response stream, with read data and an error/timeout flag.
- Allows at most one outstanding Wishbone request at any time.

Parameters:
- G_ADDR_SIZE, 8, Wishbone and command address width.
- G_DATA_SIZE, 16, Wishbone and command data width.
- G_TIMEOUT, 15, cycles from CYC assertion without an ACK before the transaction is aborted (must be >= 2).

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_n_i  in  1  synchronous, active-low reset.
- s_valid_i  in  1  command valid.
- s_ready_o  out  1  command ready.
- s_we_i  in  1  1 = write, 0 = read.
- s_addr_i  in  G_ADDR_SIZE  command address.
- s_data_i  in  G_DATA_SIZE  write data (ignored for reads).
- m_valid_o  out  1  response valid.
- m_ready_i  in  1  response ready.
- m_data_o  out  G_DATA_SIZE  read data; 0 for writes and on error.
- m_err_o  out  1  1 = transaction timed out.
- wb_cyc_o  out  1  Wishbone CYC.
- wb_stb_o  out  1  Wishbone STB.
- wb_stall_i  in  1  Wishbone STALL.
- wb_ack_i  in  1  Wishbone ACK.
- wb_we_o  out  1  Wishbone WE.
- wb_addr_o  out  G_ADDR_SIZE  Wishbone address.
- wb_data_o  out  G_DATA_SIZE  Wishbone write data.
- wb_data_i  in  G_DATA_SIZE  Wishbone read data.

Behaviour:
- Reset (rst_n_i = 0 at an edge):
  - state IDLE;
  - wb_cyc_o, wb_stb_o, wb_we_o, m_valid_o, m_err_o all 0;
  - wb_addr_o, wb_data_o, m_data_o all 0;
  - timeout counter 0.
  - Reset mid-transaction drops CYC/STB on the next edge and discards any pending response.
- All outputs are registered. s_ready_o = (state == IDLE) && rst_n_i.
- IDLE:
  - On s_valid_i && s_ready_o: latch we/addr/data onto wb_we_o/wb_addr_o/wb_data_o.
  - wb_data_o is latched only for writes, else 0.
  - Set wb_cyc_o = wb_stb_o = 1, clear counter, go to REQ.
- REQ (CYC = STB = 1):
  - While wb_stall_i = 1, hold STB, WE, ADDR and DATA unchanged.
  - At an edge with wb_stall_i = 0 the request is issued: STB goes 0, CYC stays 1, go to WAIT.
  - wb_ack_i in REQ is ignored (no outstanding request).
- WAIT (CYC = 1, STB = 0):
  - On wb_ack_i = 1: latch m_data_o = wb_data_i for reads, 0 for writes; m_err_o = 0; m_valid_o = 1.
  - In the same edge: CYC = 0, wb_we_o/addr/data cleared to 0, go to RESP.
- Timeout:
  - Counter increments every cycle in REQ or WAIT; saturates, no wrap.
  - When the counter reaches G_TIMEOUT-1 and no ACK arrives at that edge: CYC = STB = 0, m_valid_o = 1, m_err_o = 1, m_data_o = 0, go to RESP.
  - An ACK on the same edge as the timeout wins (normal response).
- RESP:
  - m_valid_o and m_data_o/m_err_o are held stable until m_valid_o && m_ready_i.
  - Then m_valid_o = 0, m_data_o = 0, m_err_o = 0, go to IDLE.
  - No new command is accepted in the same cycle.
- Wishbone rules:
  - STB never 1 while CYC is 0.
  - Exactly one request per command.
  - wb_ack_i outside WAIT is ignored.
  - CYC never drops with a request outstanding except on timeout or reset.
- Latency with a zero-stall slave (wb_mem):
  - Command accepted at edge T.
  - STB high in cycle T..T+1; request issued at edge T+1.
  - ACK seen at edge T+2.
  - m_valid_o high from T+2.
  - Next s_ready_o at the earliest after the response handshake edge.
- Throughput: one command per 4 cycles at best.
- m_data_o is 0 whenever m_valid_o = 0.

Test Plan:
- Write then read, no stall: cmd write addr 0x12 data 0xBEEF, then read 0x12 → write response m_data_o = 0, m_err_o = 0; read response m_data_o = 0xBEEF; m_valid_o rises exactly 2 cycles after each command acceptance.
- Stall hold: wb_stall_i = 1 for 3 cycles on a read of 0x05 → STB/ADDR/WE held constant for 4 cycles, exactly one request issued, response data = slave data.
- Timeout: slave never ACKs, G_TIMEOUT = 15 → CYC drops and m_valid_o = 1 with m_err_o = 1 and m_data_o = 0 on the 15th edge after acceptance; next command still works.
- Response backpressure: m_ready_i = 0 for 5 cycles → m_valid_o, m_data_o and m_err_o are stable; s_ready_o = 0 throughout; s_ready_o = 1 on the cycle after the handshake.
- Reset mid-operation: assert rst_n_i = 0 during WAIT → next cycle CYC = STB = 0, m_valid_o = 0, s_ready_o = 0 while in reset; after release, a read of 0x00 completes normally.
- Spurious ACK: wb_ack_i = 1 while IDLE and during REQ → no response generated; a later genuine ACK produces exactly one response.
